light_monitor: RTL and testbench
================================

LIGHT_MONITOR -- requirements
Module: light_monitor

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- C_INT_RED, 10, red interval [blinks].
- C_INT_GREEN, 10, green interval [blinks].
- C_INT_YELLOW, 2, yellow interval [blinks].
- C_INT_WALK, 5, walk interval [blinks].
- C_COLORS, 12'b100_010_110_111, RGB codes: [11:9] red, [8:6] green, [5:3] yellow, [2:0] walk.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single system clock.
- rstb, in, 1, reset, asynchronous, active low.
- blink, in, 1, blinker timebase level; each rising edge is one blink.
- inMode, in, 1, 1 = checking suspended.
- inClear, in, 1, one-cycle pulse that clears a latched fault.
- inLED, in, 12, RGB LED vector, four groups of R,G,B, [11:9] = LED 3 … [2:0] = LED 0.
- outState, out, 2, decoded state: 0 red, 1 green, 2 yellow, 3 walk.
- outValid, out, 1, outState holds a legal decoded color.
- outFault, out, 1, sticky fault flag.
- outFaultCode, out, 3, first fault cause.
- outBlinks, out, 8, blinks counted in the current state, saturating.

Function
REQ-003 inLED and blink shall be registered once; all decoding shall use the registered copies.
REQ-004 Decode rules:
- All four groups must be equal, else fault code 2 (mismatch).
- A group equal to a C_COLORS field maps to that state.
- 3'b000 or any unmatched code is fault code 1 (illegal color).
REQ-005 outState/outValid shall update 2 clk cycles after inLED changes; outState shall hold its last legal value while the input is illegal.
REQ-006 Blink edge = registered blink 1 with previous 0; outBlinks shall increment by 1 per edge and saturate at 255.
REQ-007 FSM states: IDLE, TRACK, FAULT.
- IDLE: wait for first legal decode, then go to TRACK with outBlinks = 0; no interval check on this first state.
- TRACK: on a state change, run the checks in REQ-008, then zero outBlinks.
- FAULT: outputs frozen except outValid/outState decoding.
REQ-008 Legal transitions: red->green, green->yellow, yellow->red, yellow->walk, walk->red. Any other transition shall give fault code 3.
REQ-009 On leaving a state with interval N, count < N-1 shall give fault code 4 (short).
REQ-010 While in a state, count > N+1 shall give fault code 5 (long), raised on the edge that makes the count N+2. The ±1 tolerance covers blink/state misalignment.
REQ-011 Fault priority when several occur in the same cycle: 2 > 1 > 3 > 4 > 5.
- outFault = 1 and code latched in the same cycle outState would reflect the event.
- FSM enters FAULT.
- Later faults shall not overwrite the latched code.
REQ-012 inClear in FAULT shall return the FSM to IDLE next cycle with outFault = 0 and outFaultCode = 0. inClear is ignored in other states.
REQ-013 While inMode = 1: FSM forced to IDLE, no faults raised, outBlinks held at 0; a latched fault persists. On inMode falling, the monitor restarts from IDLE.
REQ-014 A blink edge and a state change in the same cycle: the edge counts toward the old state before the check; the new state starts at 0.
REQ-015 Interval parameters shall be 1..253; all arithmetic is 8-bit unsigned.

Reset
REQ-016 rstb low shall asynchronously set: FSM = IDLE, outState = 0, outValid = 0, outFault = 0, outFaultCode = 0, outBlinks = 0, all pipeline registers = 0.
REQ-017 Deassertion shall take effect on the next clk rising edge. Reset mid-FAULT or mid-TRACK shall discard all history.

Verification
REQ-018 Params 3/3/1/2; drive red 3 blinks, green 3, yellow 1, walk 2, red → outFault stays 0, outState follows 0,1,2,3,0 at 2-cycle latency.
REQ-019 Green directly to red → outFault = 1, outFaultCode = 3 at the red decode cycle; inClear → code 0 and FSM in IDLE next cycle.
REQ-020 Red held for 5 blinks (N = 3) → fault code 5 on the 5th blink edge; outBlinks frozen at 5.
REQ-021 LED 2 = 3'b010 while the others = 3'b100 in the same cycle as a short-interval exit → outFaultCode = 2 (priority).
REQ-022 inMode = 1 with illegal inLED = 12'h000 → no fault, outValid = 0; inMode falls with legal red → IDLE then TRACK, outBlinks = 0.
REQ-023 rstb pulsed low asynchronously mid-green with outBlinks = 2 → all outputs 0 immediately, no clk edge required.

Source files
------------

// File: rtl/light_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | light_monitor                                                            |
// | Watches a four-head RGB traffic light, decodes its color and flags       |
// | illegal colors, head mismatches, bad sequences and off-interval phases.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module light_monitor #(
    parameter int unsigned C_INT_RED    = 10,
    parameter int unsigned C_INT_GREEN  = 10,
    parameter int unsigned C_INT_YELLOW = 2,
    parameter int unsigned C_INT_WALK   = 5,
    parameter logic [11:0] C_COLORS     = 12'b100_010_110_111
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        blink,
    input  logic        inMode,
    input  logic        inClear,
    input  logic [11:0] inLED,
    output logic [1:0]  outState,
    output logic        outValid,
    output logic        outFault,
    output logic [2:0]  outFaultCode,
    output logic [7:0]  outBlinks
);

    localparam logic [2:0] C_FC_NONE     = 3'd0;
    localparam logic [2:0] C_FC_ILLEGAL  = 3'd1;
    localparam logic [2:0] C_FC_MISMATCH = 3'd2;
    localparam logic [2:0] C_FC_TRANS    = 3'd3;
    localparam logic [2:0] C_FC_SHORT    = 3'd4;
    localparam logic [2:0] C_FC_LONG     = 3'd5;

    localparam logic [1:0] C_ST_RED    = 2'd0;
    localparam logic [1:0] C_ST_GREEN  = 2'd1;
    localparam logic [1:0] C_ST_YELLOW = 2'd2;
    localparam logic [1:0] C_ST_WALK   = 2'd3;

    localparam logic [7:0] C_N_RED    = 8'(C_INT_RED);
    localparam logic [7:0] C_N_GREEN  = 8'(C_INT_GREEN);
    localparam logic [7:0] C_N_YELLOW = 8'(C_INT_YELLOW);
    localparam logic [7:0] C_N_WALK   = 8'(C_INT_WALK);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } fsm_t;

    function automatic logic [7:0] interval_of(input logic [1:0] s);
        logic [7:0] n;
        case (s)
            C_ST_RED:    n = C_N_RED;
            C_ST_GREEN:  n = C_N_GREEN;
            C_ST_YELLOW: n = C_N_YELLOW;
            default:     n = C_N_WALK;
        endcase
        return n;
    endfunction

    function automatic logic step_allowed(input logic [1:0] from, input logic [1:0] to);
        logic ok;
        case (from)
            C_ST_RED:    ok = (to == C_ST_GREEN);
            C_ST_GREEN:  ok = (to == C_ST_YELLOW);
            C_ST_YELLOW: ok = (to == C_ST_RED) || (to == C_ST_WALK);
            default:     ok = (to == C_ST_RED);
        endcase
        return ok;
    endfunction

    logic [11:0] led_q, led_d;
    logic        blink_q, blink_d;
    logic        blink_prev_q, blink_prev_d;
    fsm_t        fsm_q, fsm_d;
    logic [1:0]  state_q, state_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [2:0]  code_q, code_d;
    logic [7:0]  blinks_q, blinks_d;

    logic        dec_legal;
    logic [1:0]  dec_state;
    logic [2:0]  dec_code;
    logic        blink_edge;
    logic [7:0]  blinks_eff;
    logic [7:0]  cur_n;
    logic [2:0]  cause;

    // Color decode works only on the registered LED copy.
    always_comb begin
        dec_legal = 1'b0;
        dec_state = C_ST_RED;
        dec_code  = C_FC_NONE;
        if ((led_q[11:9] != led_q[2:0]) || (led_q[8:6] != led_q[2:0]) ||
            (led_q[5:3] != led_q[2:0])) begin
            dec_code = C_FC_MISMATCH;
        end else if (led_q[2:0] == 3'b000) begin
            dec_code = C_FC_ILLEGAL;
        end else if (led_q[2:0] == C_COLORS[11:9]) begin
            dec_legal = 1'b1;
            dec_state = C_ST_RED;
        end else if (led_q[2:0] == C_COLORS[8:6]) begin
            dec_legal = 1'b1;
            dec_state = C_ST_GREEN;
        end else if (led_q[2:0] == C_COLORS[5:3]) begin
            dec_legal = 1'b1;
            dec_state = C_ST_YELLOW;
        end else if (led_q[2:0] == C_COLORS[2:0]) begin
            dec_legal = 1'b1;
            dec_state = C_ST_WALK;
        end else begin
            dec_code = C_FC_ILLEGAL;
        end
    end

    always_comb begin
        led_d        = inLED;
        blink_d      = blink;
        blink_prev_d = blink_q;

        blink_edge = blink_q & ~blink_prev_q;
        if (blink_edge && (blinks_q != 8'hFF)) begin
            blinks_eff = blinks_q + 8'd1;
        end else begin
            blinks_eff = blinks_q;
        end
        cur_n = interval_of(state_q);

        state_d  = dec_legal ? dec_state : state_q;
        valid_d  = dec_legal;
        fsm_d    = fsm_q;
        fault_d  = fault_q;
        code_d   = code_q;
        blinks_d = blinks_q;
        cause    = C_FC_NONE;

        if (inMode) begin
            fsm_d    = ST_IDLE;
            blinks_d = 8'd0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    blinks_d = 8'd0;
                    if (dec_legal) begin
                        fsm_d = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    // A coincident blink edge is credited to the state being left.
                    blinks_d = blinks_eff;
                    if (!dec_legal) begin
                        cause = dec_code;
                    end else if (dec_state != state_q) begin
                        blinks_d = 8'd0;
                        if (!step_allowed(state_q, dec_state)) begin
                            cause = C_FC_TRANS;
                        end else if (blinks_eff < (cur_n - 8'd1)) begin
                            cause = C_FC_SHORT;
                        end
                    end else if (blinks_eff > (cur_n + 8'd1)) begin
                        cause = C_FC_LONG;
                    end
                    if (cause != C_FC_NONE) begin
                        fsm_d = ST_FAULT;
                        if (!fault_q) begin
                            fault_d = 1'b1;
                            code_d  = cause;
                        end
                    end
                end
                ST_FAULT: begin
                    if (inClear) begin
                        fsm_d    = ST_IDLE;
                        fault_d  = 1'b0;
                        code_d   = C_FC_NONE;
                        blinks_d = 8'd0;
                    end
                end
                default: begin
                    fsm_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            led_q        <= 12'd0;
            blink_q      <= 1'b0;
            blink_prev_q <= 1'b0;
            fsm_q        <= ST_IDLE;
            state_q      <= C_ST_RED;
            valid_q      <= 1'b0;
            fault_q      <= 1'b0;
            code_q       <= C_FC_NONE;
            blinks_q     <= 8'd0;
        end else begin
            led_q        <= led_d;
            blink_q      <= blink_d;
            blink_prev_q <= blink_prev_d;
            fsm_q        <= fsm_d;
            state_q      <= state_d;
            valid_q      <= valid_d;
            fault_q      <= fault_d;
            code_q       <= code_d;
            blinks_q     <= blinks_d;
        end
    end

    assign outState     = state_q;
    assign outValid     = valid_q;
    assign outFault     = fault_q;
    assign outFaultCode = code_q;
    assign outBlinks    = blinks_q;

endmodule
`default_nettype wire

// File: tb/tb_light_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_light_monitor                                                         |
// | Directed and randomized checks of light_monitor against a color model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_light_monitor;

    localparam int RI = 3;
    localparam int GI = 3;
    localparam int YI = 1;
    localparam int WI = 2;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        blink = 1'b0;
    logic        inMode = 1'b0;
    logic        inClear = 1'b0;
    logic [11:0] inLED = 12'd0;
    logic [1:0]  outState;
    logic        outValid;
    logic        outFault;
    logic [2:0]  outFaultCode;
    logic [7:0]  outBlinks;

    light_monitor #(
        .C_INT_RED   (RI),
        .C_INT_GREEN (GI),
        .C_INT_YELLOW(YI),
        .C_INT_WALK  (WI),
        .C_COLORS    (12'b100_010_110_111)
    ) dut (
        .clk         (clk),
        .rstb        (rstb),
        .blink       (blink),
        .inMode      (inMode),
        .inClear     (inClear),
        .inLED       (inLED),
        .outState    (outState),
        .outValid    (outValid),
        .outFault    (outFault),
        .outFaultCode(outFaultCode),
        .outBlinks   (outBlinks)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: what the light looks like, what has been seen, and the verdict.
    int          ivl[4] = '{RI, GI, YI, WI};
    logic [11:0] seen_led;
    bit          seen_blk, seen_blk_old;
    int          m_color, m_count, m_code;
    bit          m_valid, m_flag, m_run, m_halt;

    function automatic logic [2:0] color_code(input int c);
        case (c)
            0:       return 3'b100;
            1:       return 3'b010;
            2:       return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    // -2 heads disagree, -1 unknown color, else color index
    function automatic int classify(input logic [11:0] v);
        logic [2:0] g;
        g = v[2:0];
        if (v[5:3] != g || v[8:6] != g || v[11:9] != g) return -2;
        if (g == 3'b000) return -1;
        for (int c = 0; c < 4; c++) if (g == color_code(c)) return c;
        return -1;
    endfunction

    function automatic bit sequence_ok(input int from, input int to);
        return (from * 4 + to) inside {1, 6, 8, 11, 12};
    endfunction

    task automatic model_reset();
        seen_led = 12'd0; seen_blk = 0; seen_blk_old = 0;
        m_color = 0; m_count = 0; m_code = 0;
        m_valid = 0; m_flag = 0; m_run = 0; m_halt = 0;
    endtask

    task automatic model_step();
        int cls, prev, n, cause;
        cls   = classify(seen_led);
        prev  = m_color;
        cause = 0;
        if (cls >= 0) m_color = cls;
        m_valid = (cls >= 0);
        if (inMode) begin
            m_run = 0; m_halt = 0; m_count = 0;
        end else if (m_halt) begin
            if (inClear) begin
                m_halt = 0; m_flag = 0; m_code = 0; m_count = 0;
            end
        end else if (!m_run) begin
            if (cls >= 0) begin m_run = 1; m_count = 0; end
        end else begin
            n = m_count + ((seen_blk && !seen_blk_old) ? 1 : 0);
            if (n > 255) n = 255;
            if (cls == -2) cause = 2;
            else if (cls == -1) cause = 1;
            else if (cls != prev) begin
                if (!sequence_ok(prev, cls)) cause = 3;
                else if (n < ivl[prev] - 1) cause = 4;
                n = 0;
            end else if (n > ivl[prev] + 1) cause = 5;
            m_count = n;
            if (cause != 0) begin
                m_run = 0; m_halt = 1;
                if (!m_flag) begin m_flag = 1; m_code = cause; end
            end
        end
        seen_blk_old = seen_blk;
        seen_blk     = blink;
        seen_led     = inLED;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("state",  16'(outState),     16'(m_color));
        check("valid",  16'(outValid),     16'(m_valid));
        check("fault",  16'(outFault),     16'(m_flag));
        check("code",   16'(outFaultCode), 16'(m_code));
        check("blinks", 16'(outBlinks),    16'(m_count));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rstb) model_reset(); else model_step();
        #1;
        compare_all();
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_blink(input int n);
        repeat (n) begin
            blink = 1'b1; tick();
            blink = 1'b0; tick();
        end
    endtask

    task automatic set_color(input int c);
        inLED = {4{color_code(c)}};
    endtask

    task automatic clear_fault();
        inClear = 1'b1; tick();
        inClear = 1'b0;
    endtask

    initial begin
        int nxt, k, r;
        model_reset();
        hold(2);
        check("rst_state", 16'(outState), 16'd0);
        check("rst_valid", 16'(outValid), 16'd0);
        rstb = 1'b1;
        hold(2);

        // Full legal cycle with 2-cycle decode latency
        set_color(0); hold(3);
        pulse_blink(3);
        set_color(1); tick();
        check("lat1_state", 16'(outState), 16'd0);
        tick();
        check("lat2_state", 16'(outState), 16'd1);
        pulse_blink(3);
        set_color(2); hold(2); pulse_blink(1);
        set_color(3); hold(2); pulse_blink(2);
        set_color(0); hold(3);
        check("cycle_fault", 16'(outFault), 16'd0);
        check("cycle_state", 16'(outState), 16'd0);

        // Green straight to red
        pulse_blink(3);
        set_color(1); hold(2); pulse_blink(3);
        set_color(0); hold(2);
        check("trans_fault", 16'(outFault), 16'd1);
        check("trans_code",  16'(outFaultCode), 16'd3);
        clear_fault();
        check("clr_code",  16'(outFaultCode), 16'd0);
        check("clr_fault", 16'(outFault), 16'd0);
        hold(2);

        // Red overstays
        pulse_blink(5);
        check("long_code",   16'(outFaultCode), 16'd5);
        check("long_blinks", 16'(outBlinks), 16'd5);
        pulse_blink(2);
        check("long_frozen", 16'(outBlinks), 16'd5);
        clear_fault(); hold(2);

        // Head mismatch coincides with a short red exit
        pulse_blink(1);
        inLED = 12'b100_010_100_100; hold(2);
        check("prio_code", 16'(outFaultCode), 16'd2);
        clear_fault(); set_color(0); hold(2);

        // Suspended checking with dark LEDs
        inMode = 1'b1; inLED = 12'h000; hold(4);
        check("mode_fault", 16'(outFault), 16'd0);
        check("mode_valid", 16'(outValid), 16'd0);
        inMode = 1'b0; set_color(0); hold(2);
        check("mode_blinks", 16'(outBlinks), 16'd0);
        pulse_blink(1);
        check("mode_track", 16'(outBlinks), 16'd1);

        // Asynchronous reset mid-green
        pulse_blink(2);
        set_color(1); hold(2); pulse_blink(2);
        check("pre_rst_blinks", 16'(outBlinks), 16'd2);
        #2 rstb = 1'b0;
        #1 model_reset();
        check("arst_state",  16'(outState), 16'd0);
        check("arst_valid",  16'(outValid), 16'd0);
        check("arst_blinks", 16'(outBlinks), 16'd0);
        check("arst_fault",  16'(outFault), 16'd0);
        check("arst_code",   16'(outFaultCode), 16'd0);
        tick();
        rstb = 1'b1;
        hold(2);

        // Randomized light sequences
        for (int seg = 0; seg < 120; seg++) begin
            r = $urandom_range(0, 29);
            if (m_halt && $urandom_range(0, 1) == 1) clear_fault();
            if (r == 0) begin
                inLED = {4{color_code($urandom_range(0, 3))}};
                inLED[8:6] = inLED[2:0] ^ 3'b001;
            end else if (r == 1) begin
                inLED = 12'h000;
            end else if (r <= 3) begin
                set_color($urandom_range(0, 3));
            end else if (r == 4) begin
                inMode = 1'b1;
            end else if (r == 5) begin
                rstb = 1'b0;
            end else begin
                case (m_color)
                    0: nxt = 1;
                    1: nxt = 2;
                    2: nxt = ($urandom_range(0, 1) == 1) ? 3 : 0;
                    default: nxt = 0;
                endcase
                set_color(nxt);
            end
            k = $urandom_range(2, 14);
            for (int i = 0; i < k; i++) begin
                blink = 1'($urandom_range(0, 1));
                tick();
            end
            inMode = 1'b0;
            rstb   = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
